// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU sequencer: latched opcode, FSM states,
// and the bit-counter width helper.
package alu_pkg;

    typedef struct packed {
        logic s1;
        logic s0;
        logic m;
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ser_state_t;

    // Counter must be able to hold WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial sequencer for a 1-bit ALU slice: feeds operand bits LSB first,
// recirculates the slice carry and collects the slice outputs into a result.
// Optional Zero flag output is enabled with `define ZERO_FLAG_EN.
module bit_serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             CarryIn,
    input  logic             OpS1,
    input  logic             OpS0,
    input  logic             OpM,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             SliceA,
    output logic             SliceB,
    output logic             SliceC,
    output logic             SliceS1,
    output logic             SliceS0,
    output logic             SliceM,
    input  logic             SliceF,
    input  logic             SliceCout
`ifdef ZERO_FLAG_EN
    ,
    output logic             Zero
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    ser_state_t       state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    // Holds only the WIDTH-1 bits gathered so far; the final bit arrives live.
    logic [WIDTH-2:0] res_sh_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    alu_op_t          op_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_out_reg;
    logic             accept, last_bit;
    logic [WIDTH-1:0] shift_next;

    assign shift_next = {SliceF, res_sh_reg};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        last_bit   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == LAST_CNT) begin
                    last_bit   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // Back-to-back: a held Start restarts without an IDLE cycle.
                if (Start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_reg         <= '0;
            b_reg         <= '0;
            res_sh_reg    <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            op_reg        <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
        end else if (accept) begin
            a_reg      <= OpA;
            b_reg      <= OpB;
            carry_reg  <= CarryIn;
            cnt_reg    <= '0;
            op_reg     <= '{s1: OpS1, s0: OpS0, m: OpM};
        end else if (state_reg == RUN) begin
            a_reg      <= {1'b0, a_reg[WIDTH-1:1]};
            b_reg      <= {1'b0, b_reg[WIDTH-1:1]};
            res_sh_reg <= shift_next[WIDTH-1:1];
            carry_reg  <= SliceCout;
            cnt_reg    <= cnt_reg + CW'(1);
            if (last_bit) begin
                result_reg    <= shift_next;
                carry_out_reg <= SliceCout;
            end
        end
    end

`ifdef ZERO_FLAG_EN
    logic zero_reg;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            zero_reg <= 1'b0;
        end else if (state_reg == RUN && last_bit) begin
            zero_reg <= (shift_next == '0);
        end
    end

    assign Zero = zero_reg;
`endif

    assign Busy     = (state_reg == RUN);
    assign Done     = (state_reg == DONE);
    assign Result   = result_reg;
    assign CarryOut = carry_out_reg;
    assign SliceA   = Busy & a_reg[0];
    assign SliceB   = Busy & b_reg[0];
    assign SliceC   = Busy & carry_reg;
    assign SliceS1  = op_reg.s1;
    assign SliceS0  = op_reg.s0;
    assign SliceM   = op_reg.m;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed bench for bit_serial_alu_ctrl with the slice modelled as a full adder.
module tb_bit_serial_alu_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             carry_in = 1'b0;
    logic             op_s1 = 1'b0;
    logic             op_s0 = 1'b0;
    logic             op_m = 1'b0;
    logic             busy, done, carry_out;
    logic [WIDTH-1:0] result;
    logic             slice_a, slice_b, slice_c, slice_s1, slice_s0, slice_m;
    logic             slice_f, slice_cout;
`ifdef ZERO_FLAG_EN
    logic             zero;
`endif

    int checks = 0;
    int failures = 0;

    assign slice_f    = slice_a ^ slice_b ^ slice_c;
    assign slice_cout = (slice_a & slice_b) | (slice_a & slice_c) | (slice_b & slice_c);

    always #5 clk = ~clk;

    bit_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .OpA(op_a), .OpB(op_b),
        .CarryIn(carry_in), .OpS1(op_s1), .OpS0(op_s0), .OpM(op_m),
        .Busy(busy), .Done(done), .Result(result), .CarryOut(carry_out),
        .SliceA(slice_a), .SliceB(slice_b), .SliceC(slice_c),
        .SliceS1(slice_s1), .SliceS0(slice_s0), .SliceM(slice_m),
        .SliceF(slice_f), .SliceCout(slice_cout)
`ifdef ZERO_FLAG_EN
        , .Zero(zero)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation and checks every RUN cycle plus the DONE/IDLE cycles.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [2:0] op,
                          input logic [7:0] exp_res, input logic exp_cout, input logic exp_zero);
        logic c;
        start = 1'b1; op_a = a; op_b = b; carry_in = cin;
        {op_s1, op_s0, op_m} = op;
        tick();
        start = 1'b0;
        c = cin;
        for (int i = 0; i < WIDTH; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL %s busy/done cyc %0d: got %b/%b want 1/0", name, i, busy, done);
            end
            checks++;
            if ({slice_a, slice_b, slice_c} !== {a[i], b[i], c}) begin
                failures++;
                $display("FAIL %s slice abc cyc %0d: got %b want %b", name, i,
                         {slice_a, slice_b, slice_c}, {a[i], b[i], c});
            end
            checks++;
            if ({slice_s1, slice_s0, slice_m} !== op) begin
                failures++;
                $display("FAIL %s slice op cyc %0d: got %b want %b", name, i,
                         {slice_s1, slice_s0, slice_m}, op);
            end
            c = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== exp_res || carry_out !== exp_cout) begin
            failures++;
            $display("FAIL %s done: done=%b busy=%b res=%h cout=%b want 1 0 %h %b",
                     name, done, busy, result, carry_out, exp_res, exp_cout);
        end
`ifdef ZERO_FLAG_EN
        checks++;
        if (zero !== exp_zero) begin
            failures++;
            $display("FAIL %s zero: got %b want %b", name, zero, exp_zero);
        end
`else
        if (exp_zero !== exp_zero) $display("unreachable");
`endif
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res ||
            {slice_a, slice_b, slice_c} !== 3'b000 || {slice_s1, slice_s0, slice_m} !== op) begin
            failures++;
            $display("FAIL %s idle: done=%b busy=%b res=%h abc=%b op=%b want 0 0 %h 000 %b",
                     name, done, busy, result, {slice_a, slice_b, slice_c},
                     {slice_s1, slice_s0, slice_m}, exp_res, op);
        end
        $display("op %s a=%h b=%h cin=%b res=%h cout=%b", name, a, b, cin, result, carry_out);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || carry_out !== 1'b0 ||
            {slice_a, slice_b, slice_c, slice_s1, slice_s0, slice_m} !== 6'b0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b res=%h cout=%b slices=%b", busy, done,
                     result, carry_out, {slice_a, slice_b, slice_c, slice_s1, slice_s0, slice_m});
        end
        rst = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_add_basic();
        run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 3'b000, 8'h7F, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 3'b000, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_carry_in();
        run_op("cin_only", 8'h00, 8'h00, 1'b1, 3'b000, 8'h01, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        start = 1'b1; op_a = 8'h35; op_b = 8'h4A; carry_in = 1'b0;
        {op_s1, op_s0, op_m} = 3'b000;
        tick();
        start = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == 4) begin
                start = 1'b1; op_a = 8'hAA; op_s1 = 1'b1;
            end else begin
                start = 1'b0; op_a = 8'h35; op_s1 = 1'b0;
            end
            tick();
        end
        start = 1'b0; op_s1 = 1'b0;
        checks++;
        if (done !== 1'b1 || result !== 8'h7F || carry_out !== 1'b0 || slice_s1 !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start: done=%b res=%h cout=%b s1=%b want 1 7f 0 0",
                     done, result, carry_out, slice_s1);
        end
        start = 1'b1; op_a = 8'h10; op_b = 8'h20; carry_in = 1'b0;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || result !== 8'h7F) begin
            failures++;
            $display("FAIL b2b_restart: busy=%b done=%b res=%h want 1 0 7f", busy, done, result);
        end
        for (int i = 1; i < WIDTH; i++) tick();
        tick();
        checks++;
        if (done !== 1'b1 || result !== 8'h30 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL b2b_result: done=%b res=%h cout=%b want 1 30 0", done, result, carry_out);
        end
        tick();
        $display("back_to_back res=%h", result);
    endtask

    task automatic test_opcode();
        run_op("op_101", 8'h12, 8'h34, 1'b0, 3'b101, 8'h46, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        start = 1'b1; op_a = 8'hC3; op_b = 8'h5A; carry_in = 1'b1;
        {op_s1, op_s0, op_m} = 3'b111;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || carry_out !== 1'b0 ||
            {slice_a, slice_b, slice_c, slice_s1, slice_s0, slice_m} !== 6'b0) begin
            failures++;
            $display("FAIL abort: busy=%b done=%b res=%h cout=%b slices=%b", busy, done,
                     result, carry_out, {slice_a, slice_b, slice_c, slice_s1, slice_s0, slice_m});
        end
        for (int i = 0; i < WIDTH + 2; i++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_quiet cyc %0d: done=%b busy=%b want 0 0", i, done, busy);
            end
            tick();
        end
        $display("abort checked");
        run_op("after_abort", 8'h81, 8'h81, 1'b1, 3'b000, 8'h03, 1'b1, 1'b0);
    endtask

    initial begin
        tick();
        test_reset();
        test_add_basic();
        test_overflow();
        test_carry_in();
        test_back_to_back();
        test_opcode();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu_ctrl.md
Name: bit_serial_alu_ctrl

Overview:
Sequencer that drives the 1-bit ALU slice (Mock1) bit-serially, LSB first, to perform a WIDTH-bit operation.
- Latches operands, carry-in and opcode on Start.
- Presents one bit pair plus the running carry to the slice each cycle, and feeds the slice's Cout back through a carry flop.
- Shifts the slice's Fi into a result register.
- Sits directly upstream of, and also consumes, the slice; this is the slice's only driver.

Parameters:
WIDTH, 8, operand/result width in bits (>=2).

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  synchronous, active-high reset
Start  input  1  request; sampled only in IDLE or DONE
OpA  input  WIDTH  operand A, latched on accepted Start
OpB  input  WIDTH  operand B, latched on accepted Start
CarryIn  input  1  initial carry, latched on accepted Start
OpS1  input  1  slice select S1, latched on accepted Start
OpS0  input  1  slice select S0, latched on accepted Start
OpM  input  1  slice mode M, latched on accepted Start
Busy  output  1  high while in RUN
Done  output  1  one-cycle completion pulse
Result  output  WIDTH  last completed result, held
CarryOut  output  1  final slice Cout of last completed operation, held
SliceA  output  1  to slice Ai
SliceB  output  1  to slice Bi
SliceC  output  1  to slice Ci
SliceS1  output  1  to slice S1
SliceS0  output  1  to slice S0
SliceM  output  1  to slice M
SliceF  input  1  from slice Fi
SliceCout  input  1  from slice Cout

Behaviour:
- Reset: state IDLE; Busy, Done, Result, CarryOut, internal shift registers, carry flop, bit counter and latched opcode all 0; all Slice* outputs 0.
- States:
  - IDLE: Start=1 at an edge loads OpA, OpB, CarryIn (into the carry flop) and the opcode; clears the counter; goes to RUN.
  - RUN: counts WIDTH edges.
  - DONE: lasts exactly one cycle, with Done=1. Start=1 at the DONE exit edge is accepted and goes straight to RUN (back-to-back). Otherwise DONE goes to IDLE.
- RUN datapath:
  - SliceA/SliceB are the LSBs of the A/B shift registers; SliceC is the carry flop. All three are combinational from registers, with no registered delay.
  - Each RUN edge: A and B shift right; the result shift register shifts right inserting SliceF at the MSB; carry flop <= SliceCout; counter increments.
- Completion: on RUN edge number WIDTH, Result <= final shift value (including that edge's SliceF), CarryOut <= SliceCout, and state goes to DONE.
- Latency: Start accepted at edge 0 gives Done high between edges WIDTH and WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- Outside RUN: SliceA/B/C = 0.
- SliceS1/S0/M always reflect the latched opcode; they are stable for the whole operation and held afterwards.
- Start during RUN is ignored; latched values must not change.
- Result/CarryOut change only at completion; no partial values are visible.
- Rst asserted mid-RUN aborts at that edge with full reset values. Done does not pulse, and the aborted result is discarded.
- The block does not interpret the opcode. In logic mode (M=1) the carry is still tracked and CarryOut is reported unmodified.

Optional Feature:
ZERO_FLAG_EN
- Defined: extra output Zero (1 bit), registered at completion as (final result == 0) and held with Result. Reset value 0.
- Undefined: the Zero port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - alu_op_t packed struct {S1, S0, M};
  - ser_state_t enum {IDLE, RUN, DONE};
  - function for counter width, $clog2(WIDTH+1).
- No sub-module; shift registers and counter stay inline.
- The slice (Mock1) is instantiated at the level above, not inside this block.

Test Plan:
Bench models the slice as a full adder (F = A^B^C, Cout = majority), WIDTH=8.
1. OpA=0x35, OpB=0x4A, CarryIn=0, Start one cycle -> Busy high 8 cycles; Done pulses once between edges 8 and 9; Result=0x7F; CarryOut=0.
2. OpA=0xFF, OpB=0x01, CarryIn=0 -> Result=0x00, CarryOut=1; Zero=1 when ZERO_FLAG_EN is defined.
3. OpA=0x00, OpB=0x00, CarryIn=1 -> Result=0x01, CarryOut=0; SliceC=1 only in the first RUN cycle.
4. Start pulsed at RUN cycle 4 with OpA=0xAA -> ignored, original result unchanged. Start held through DONE -> second operation begins immediately, with no IDLE cycle.
5. Rst asserted at RUN cycle 3 -> next cycle Busy=0, Done=0, Result=0x00, Slice* outputs 0; a subsequent Start completes correctly.
6. OpS1=1, OpS0=0, OpM=1 -> SliceS1/S0/M = 1/0/1 on every RUN cycle and held after Done; the Result/CarryOut update path is unaffected.
